// File: rtl/alu_md_unit_if.sv
// Request/response bundle between the execute stage and the ALU / mul-div unit.
// The master side issues operations; the slave side is the unit itself.
interface alu_md_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic            funct7_bit5;
    logic            funct7_bit0;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            out_valid;
    logic [XLEN-1:0] ALU_result;

    modport master (
        output in_valid, funct3, funct7_bit5, funct7_bit0, operand1, operand2,
        input  in_ready, out_valid, ALU_result
    );

    modport slave (
        input  in_valid, funct3, funct7_bit5, funct7_bit0, operand1, operand2,
        output in_ready, out_valid, ALU_result
    );
endinterface

// File: rtl/alu_md_unit.sv
// Registered RV integer ALU: base ops in one cycle, M-extension ops through an
// iterative radix-2 multiplier / restoring divider taking XLEN cycles.
module alu_md_unit #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_md_unit_if.slave  bus
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              is_m;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   base_result;
    logic              a_signed, b_signed, a_sign, b_sign;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_result;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc, mul_prod;
    logic [XLEN-1:0]   mul_result;
    logic [XLEN:0]     div_trial, div_diff;
    logic [2*XLEN-1:0] div_acc;
    logic [XLEN-1:0]   div_quo, div_rem, div_result;

    assign bus.in_ready   = (state_q == IDLE) || (state_q == DONE);
    assign bus.out_valid  = out_valid_q;
    assign bus.ALU_result = result_q;
    assign accept         = bus.in_valid && bus.in_ready;
    assign is_m           = (M_EXT != 0) && bus.funct7_bit0;
    assign shamt          = bus.operand2[SW-1:0];

    always_comb begin
        base_result = '0;
        case (bus.funct3)
            3'b000: base_result = bus.funct7_bit5 ? bus.operand1 - bus.operand2
                                                  : bus.operand1 + bus.operand2;
            3'b001: base_result = bus.operand1 << shamt;
            3'b010: base_result = {{(XLEN-1){1'b0}}, $signed(bus.operand1) < $signed(bus.operand2)};
            3'b011: base_result = {{(XLEN-1){1'b0}}, bus.operand1 < bus.operand2};
            3'b100: base_result = bus.operand1 ^ bus.operand2;
            3'b101: base_result = bus.funct7_bit5 ? $unsigned($signed(bus.operand1) >>> shamt)
                                                  : bus.operand1 >> shamt;
            3'b110: base_result = bus.operand1 | bus.operand2;
            default: base_result = bus.operand1 & bus.operand2;
        endcase
    end

    // MUL keeps unsigned magnitudes since its low half does not depend on signedness.
    always_comb begin
        a_signed    = bus.funct3[2] ? ~bus.funct3[0]
                                    : (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
        b_signed    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3 == 3'b001);
        a_sign      = a_signed && bus.operand1[XLEN-1];
        b_sign      = b_signed && bus.operand2[XLEN-1];
        a_mag       = a_sign ? -bus.operand1 : bus.operand1;
        b_mag       = b_sign ? -bus.operand2 : bus.operand2;
        div_zero    = (bus.operand2 == '0);
        div_ovf     = !bus.funct3[0] && (bus.operand1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.operand2 == '1);
        fast_result = bus.funct3[1] ? (div_zero ? bus.operand1 : '0)
                                    : (div_zero ? '1 : bus.operand1);
    end

    // acc_q holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc    = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod   = neg_q ? -mul_acc : mul_acc;
        mul_result = (op_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

        div_trial  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff   = div_trial - {1'b0, opb_q};
        div_acc    = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        div_quo    = div_acc[XLEN-1:0];
        div_rem    = div_acc[2*XLEN-1:XLEN];
        div_result = op_q[1] ? (rem_neg_q ? -div_rem : div_rem)
                             : (neg_q ? -div_quo : div_quo);
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        op_d        = op_q;
        neg_d       = neg_q;
        rem_neg_d   = rem_neg_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d = bus.funct3;
                    if (!is_m) begin
                        result_d    = base_result;
                        out_valid_d = 1'b1;
                    end else if (bus.funct3[2] && (div_zero || div_ovf)) begin
                        result_d    = fast_result;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d   = bus.funct3[2] ? DIV : MUL;
                        count_d   = '0;
                        neg_d     = a_sign ^ b_sign;
                        rem_neg_d = a_sign;
                        acc_d     = bus.funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        opb_d     = bus.funct3[2] ? b_mag : a_mag;
                    end
                end
            end
            MUL, DIV: begin
                acc_d   = (state_q == MUL) ? mul_acc : div_acc;
                count_d = count_q + SW'(1);
                if (count_q == SW'(XLEN-1)) begin
                    state_d     = DONE;
                    count_d     = '0;
                    out_valid_d = 1'b1;
                    result_d    = (state_q == MUL) ? mul_result : div_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end
endmodule

// File: tb/tb_alu_md_unit.sv
// Scoreboard bench for alu_md_unit: the driver queues hand-computed results with
// their due cycle; a negedge monitor checks every out_valid and in_ready.
module tb_alu_md_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;

    alu_md_unit_if #(.XLEN(XLEN)) bus();

    alu_md_unit #(.XLEN(XLEN), .M_EXT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] expVal[$];
    int              expCyc[$];
    string           expName[$];
    int busyFrom = 1;
    int busyTo   = 0;

    logic [XLEN-1:0] monVal;
    int              monCyc;
    string           monName;

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("in_ready", XLEN'(bus.in_ready),
                        XLEN'(!(cyc >= busyFrom && cyc <= busyTo)));
            if (bus.out_valid) begin
                if (expVal.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected out_valid: got result 0x%h at cycle %0d, expected no output",
                             bus.ALU_result, cyc);
                end else begin
                    monVal  = expVal.pop_front();
                    monCyc  = expCyc.pop_front();
                    monName = expName.pop_front();
                    checkOutput(monName, bus.ALU_result, monVal);
                    checkOutput({monName, " cycle"}, XLEN'(cyc), XLEN'(monCyc));
                end
            end
        end
    end

    // Holds in_valid until accepted, so a busy unit makes the request wait in place.
    task automatic applyStimulus(input logic b0, input logic b5, input logic [2:0] f3,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] expv, input int lat,
                                 input string name, output int acceptCyc);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.funct7_bit0 = b0;
        bus.funct7_bit5 = b5;
        bus.funct3      = f3;
        bus.operand1    = a;
        bus.operand2    = b;
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s accept: in_ready got 0 after 100 cycles, expected 1", name);
            acceptCyc = -1;
        end else begin
            acceptCyc = cyc;
            expVal.push_back(expv);
            expCyc.push_back(cyc + lat);
            expName.push_back(name);
            if (lat > 1) begin
                busyFrom = cyc + 1;
                busyTo   = cyc + lat - 1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.operand1 = '1;
        bus.operand2 = '1;
    endtask

    initial begin
        int t0, t1, waited;
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.funct3      = 3'b000;
        bus.funct7_bit5 = 1'b0;
        bus.funct7_bit0 = 1'b0;
        bus.operand1    = '0;
        bus.operand2    = '0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready",   XLEN'(bus.in_ready),  XLEN'(1));
        checkOutput("reset out_valid",  XLEN'(bus.out_valid), XLEN'(0));
        checkOutput("reset ALU_result", bus.ALU_result,       32'h0);

        applyStimulus(0, 0, 3'b000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, "ADD wrap", t0);
        applyStimulus(0, 1, 3'b000, 32'h0,         32'h1,         32'hFFFF_FFFF, 1, "SUB 0-1", t0);
        applyStimulus(0, 1, 3'b101, 32'h8000_0000, 32'h4,         32'hF800_0000, 1, "SRA", t0);
        applyStimulus(0, 0, 3'b010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1, "SLT", t0);
        applyStimulus(0, 0, 3'b011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, "SLTU", t0);
        applyStimulus(0, 0, 3'b001, 32'h1,         32'd33,        32'h2,         1, "SLL by 33", t0);
        applyStimulus(0, 0, 3'b101, 32'h8000_0000, 32'h4,         32'h0800_0000, 1, "SRL", t0);
        applyStimulus(0, 0, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1, "XOR", t0);
        applyStimulus(0, 0, 3'b110, 32'h0000_FFFF, 32'h00FF_0000, 32'h00FF_FFFF, 1, "OR", t0);
        applyStimulus(0, 0, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, "AND", t0);

        applyStimulus(1, 0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH", t0);
        applyStimulus(1, 0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU", t0);
        applyStimulus(1, 0, 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, "MUL 2^32", t0);
        applyStimulus(1, 0, 3'b000, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7*-3", t0);
        applyStimulus(1, 0, 3'b010, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33, "MULHSU", t0);

        applyStimulus(1, 0, 3'b100, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, "DIV -7/2", t0);
        applyStimulus(1, 0, 3'b110, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, "REM -7/2", t0);
        applyStimulus(1, 0, 3'b101, 32'd100,       32'd7,         32'd14,        33, "DIVU 100/7", t0);
        applyStimulus(1, 0, 3'b111, 32'd100,       32'd7,         32'd2,         33, "REMU 100/7", t0);
        applyStimulus(1, 0, 3'b100, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2", t0);
        applyStimulus(1, 0, 3'b110, 32'h7,         32'hFFFF_FFFE, 32'h1,         33, "REM 7/-2", t0);

        applyStimulus(1, 0, 3'b100, 32'h5,         32'h0,         32'hFFFF_FFFF, 1, "DIV by 0", t0);
        applyStimulus(1, 0, 3'b111, 32'h5,         32'h0,         32'h5,         1, "REMU by 0", t0);
        applyStimulus(1, 0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV overflow", t0);
        applyStimulus(1, 0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "REM overflow", t0);

        // Abort a divide with reset ten cycles in; its result must never appear.
        applyStimulus(1, 0, 3'b101, 32'd100, 32'd7, 32'd14, 33, "DIVU aborted", t0);
        while (cyc < t0 + 10) @(negedge clk);
        #1;
        reset = 1'b1;
        expVal.delete();
        expCyc.delete();
        expName.delete();
        busyFrom = 1;
        busyTo   = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after abort",  XLEN'(bus.in_ready),  XLEN'(1));
        checkOutput("out_valid after abort", XLEN'(bus.out_valid), XLEN'(0));
        repeat (40) @(negedge clk);

        // Second request issued while busy waits and is taken in the DONE cycle.
        applyStimulus(1, 0, 3'b101, 32'd100, 32'd7, 32'd14, 33, "DIVU first", t0);
        applyStimulus(1, 0, 3'b111, 32'd100, 32'd7, 32'd2,  33, "REMU held", t1);
        checkOutput("held accept cycle", XLEN'(t1), XLEN'(t0 + 33));

        waited = 0;
        while (expVal.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard drained", XLEN'(expVal.size()), XLEN'(0));
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised successor to the single-cycle RV32I ALU.
- Registered ALU of width XLEN with valid/ready handshake.
- Executes the RV base integer ops with 1-cycle latency, and the RV M-extension (MUL*/DIV*/REM*) with an iterative XLEN-cycle multiplier/divider.
- Sits in the execute stage; the pipeline stalls on in_ready low.

Parameters:
- XLEN, 32, datapath width; 32 or 64; shift amount uses low $clog2(XLEN) bits of operand2.
- M_EXT, 1, 1 = M-extension implemented; 0 = funct7_bit0 ignored and every op is a base op.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request this cycle
- funct3  input  3  operation select (RV encoding)
- funct7_bit5  input  1  SUB/SRA select (base ops only)
- funct7_bit0  input  1  1 = M-extension op (when M_EXT=1)
- operand1  input  XLEN  rs1 / dividend / multiplicand
- operand2  input  XLEN  rs2 / divisor / multiplier
- out_valid  output  1  one-cycle pulse: ALU_result valid
- ALU_result  output  XLEN  registered result, held until the next out_valid

Behaviour:
- Accept: a request is accepted in cycle T when in_valid && in_ready at the rising edge ending T. Operands and function fields are captured at acceptance; later input changes are ignored.
- Reset: state IDLE, counter 0, out_valid 0, ALU_result 0, in_ready 1 from the cycle after reset deasserts. Reset mid-operation aborts it: no out_valid, result discarded.
- Base ops (funct7_bit0=0, or M_EXT=0): out_valid=1 in T+1.
  - 000: ADD, or SUB if funct7_bit5.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if funct7_bit5.
  - 110: OR.
  - 111: AND.
  - Add/sub wrap modulo 2^XLEN. SLT/SLTU return 1 or 0 zero-extended.
  - in_ready stays 1, so one base op per cycle is sustained.
- M ops (funct7_bit0=1):
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high XLEN bits, signed×signed.
  - 010 MULHSU: high XLEN bits, signed×unsigned.
  - 011 MULHU: high XLEN bits, unsigned×unsigned.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM: IDLE -> MUL or DIV on acceptance of an M op -> DONE after XLEN iterations -> IDLE.
  - in_ready=0 in cycles T+1..T+XLEN.
  - out_valid=1 and in_ready=1 in T+XLEN+1, so a new request may be accepted in that cycle.
- Multiply: signed operands are converted to magnitudes. XLEN iterations of radix-2 shift-add into a 2*XLEN accumulator. The product is negated when the operand signs differ (signed cases only).
- Divide: restoring division on magnitudes over XLEN iterations. For signed ops the quotient is negated if the signs differ, and the remainder takes the dividend's sign.
- Fast paths, with out_valid in T+1 and no busy period:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give operand1.
  - Signed overflow (operand1 = -2^(XLEN-1), operand2 = -1): DIV gives operand1; REM gives 0.
- in_valid while in_ready=0 is not accepted. The requester holds the request; there is no queueing.
- out_valid is never high for two consecutive cycles from a single request.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 1 accepted in T -> out_valid in T+1, result 0x80000000. SUB 0 - 1 -> 0xFFFFFFFF.
- Back-to-back base ops: SRA 0x80000000 >> 4, SLT -1 < 1, SLTU 0xFFFFFFFF < 1, operand2 shift amount 33 (uses 1) -> results 0xF8000000, 1, 0, and shift-by-1 in consecutive cycles, in_ready stuck at 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MUL 0x00010000 × 0x00010000 -> 0. For each: out_valid exactly at T+33, in_ready low T+1..T+32.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2. Latency is 33 cycles each.
- DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; REM 0x80000000 / -1 -> 0. All with out_valid at T+1.
- Reset asserted at T+10 of a DIV -> no out_valid, in_ready=1 after reset. in_valid held during busy -> accepted only at T+33, and a second result arrives 33 cycles later.
